// File: rtl/ps_frame_ctrl_pkg.sv
// Shared definitions for the frame controller: FSM encodings, field widths
// and the default frame geometry / flush length.
package ps_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_SOF = 3'd0,
    ST_FLUSH    = 3'd1,
    ST_RUN      = 3'd2,
    ST_DRAIN    = 3'd3
  } ps_state_e;

  localparam int DEF_FLUSH_CYCLES = 4;
  localparam int DEF_FRAME_PIXELS = 307200;  // 640x480

  localparam int PIX_CNT_W   = 19;
  localparam int THR_W       = 22;
  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/ps_frame_ctrl.sv
// Per-frame control for the sobel filter: double-buffers configuration so it
// only changes at frame starts, issues a fixed-length flush at each start,
// counts pixel reads and signals when a frame has fully drained.
module ps_frame_ctrl
  import ps_frame_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int FRAME_PIXELS = DEF_FRAME_PIXELS
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_cfg_wr,
  input  logic               i_cfg_enable,
  input  logic [THR_W-1:0]   i_cfg_threshold,
  input  logic               i_sof,
  input  logic               i_pix_rd,
  input  logic               i_obuf_empty,
  output logic               o_enable,
  output logic [THR_W-1:0]   o_threshold,
  output logic               o_flush,
  output logic               o_cfg_pending,
  output logic               o_frame_done,
  output logic [FRAME_CNT_W-1:0] o_frame_cnt,
  output logic               o_err_short,
  output logic [2:0]         o_state
);

  // Flush counter counts down from FLUSH_CYCLES-1 to 0, so it needs at least one bit.
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0]        FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);
  localparam logic [PIX_CNT_W-1:0] LAST_PIX   = PIX_CNT_W'(FRAME_PIXELS - 1);

  ps_state_e               state_reg, state_next;
  logic [FW-1:0]           flush_cnt_reg, flush_cnt_next;
  logic [PIX_CNT_W-1:0]    pix_cnt_reg, pix_cnt_next;
  logic                    shadow_en_reg, shadow_en_next;
  logic [THR_W-1:0]        shadow_thr_reg, shadow_thr_next;
  logic                    enable_reg, enable_next;
  logic [THR_W-1:0]        thr_reg, thr_next;
  logic                    flush_reg, flush_next;
  logic                    pending_reg, pending_next;
  logic                    done_reg, done_next;
  logic [FRAME_CNT_W-1:0]  frame_cnt_reg, frame_cnt_next;
  logic                    err_reg, err_next;
  logic                    apply;

  // State and all output registers; reset clears everything immediately.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg      <= ST_WAIT_SOF;
      flush_cnt_reg  <= '0;
      pix_cnt_reg    <= '0;
      shadow_en_reg  <= 1'b0;
      shadow_thr_reg <= '0;
      enable_reg     <= 1'b0;
      thr_reg        <= '0;
      flush_reg      <= 1'b0;
      pending_reg    <= 1'b0;
      done_reg       <= 1'b0;
      frame_cnt_reg  <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      flush_cnt_reg  <= flush_cnt_next;
      pix_cnt_reg    <= pix_cnt_next;
      shadow_en_reg  <= shadow_en_next;
      shadow_thr_reg <= shadow_thr_next;
      enable_reg     <= enable_next;
      thr_reg        <= thr_next;
      flush_reg      <= flush_next;
      pending_reg    <= pending_next;
      done_reg       <= done_next;
      frame_cnt_reg  <= frame_cnt_next;
      err_reg        <= err_next;
    end
  end

  // Next-state logic: frame sequencing, config apply and shadow capture.
  always_comb begin
    state_next      = state_reg;
    flush_cnt_next  = flush_cnt_reg;
    pix_cnt_next    = pix_cnt_reg;
    shadow_en_next  = shadow_en_reg;
    shadow_thr_next = shadow_thr_reg;
    enable_next     = enable_reg;
    thr_next        = thr_reg;
    flush_next      = flush_reg;
    pending_next    = pending_reg;
    done_next       = 1'b0;
    frame_cnt_next  = frame_cnt_reg;
    err_next        = err_reg;
    apply           = 1'b0;

    unique case (state_reg)
      ST_WAIT_SOF: begin
        if (i_sof) apply = 1'b1;
      end
      ST_FLUSH: begin
        // A start pulse here is deliberately ignored: the flush always runs to length.
        pix_cnt_next = '0;
        if (flush_cnt_reg == '0) begin
          flush_next = 1'b0;
          state_next = ST_RUN;
        end else begin
          flush_cnt_next = flush_cnt_reg - FW'(1);
        end
      end
      ST_RUN: begin
        if (i_sof) begin
          apply    = 1'b1;
          err_next = 1'b1;
        end else if (i_pix_rd) begin
          pix_cnt_next = pix_cnt_reg + PIX_CNT_W'(1);
          if (pix_cnt_reg == LAST_PIX) state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (i_sof) begin
          apply    = 1'b1;
          err_next = 1'b1;
        end else if (i_obuf_empty) begin
          done_next      = 1'b1;
          frame_cnt_next = frame_cnt_reg + 16'd1;
          state_next     = ST_WAIT_SOF;
        end
      end
      default: state_next = ST_WAIT_SOF;
    endcase

    // Apply uses the shadow as it stood before any same-cycle write.
    if (apply) begin
      enable_next    = shadow_en_reg;
      thr_next       = shadow_thr_reg;
      pending_next   = 1'b0;
      flush_next     = 1'b1;
      flush_cnt_next = FLUSH_LOAD;
      state_next     = ST_FLUSH;
    end

    // A write always lands in the shadow, even when it coincides with an apply.
    if (i_cfg_wr) begin
      shadow_en_next  = i_cfg_enable;
      shadow_thr_next = i_cfg_threshold;
      pending_next    = 1'b1;
    end
  end

  assign o_enable      = enable_reg;
  assign o_threshold   = thr_reg;
  assign o_flush       = flush_reg;
  assign o_cfg_pending = pending_reg;
  assign o_frame_done  = done_reg;
  assign o_frame_cnt   = frame_cnt_reg;
  assign o_err_short   = err_reg;
  assign o_state       = state_reg;

endmodule
